shift_req_queue: RTL and testbench

- Sequential front-end/back-end wrapper around the 8-bit combinational barrel shifter.
- Accepts shift requests over a valid/ready handshake and buffers them in a small FIFO.
- Applies the head request to a barrel-shifter sub-module and registers the result into an output stage with its own valid/ready handshake.
- Decouples request producers (keyboard/switch decode, CPU ALU issue) from result consumers (display, register write-back).

---
 rtl/shift_pkg.sv | 18 +
 rtl/shift_req_queue_if.sv | 30 +++
 rtl/barrel_shifter.sv | 37 +++
 rtl/shift_req_queue.sv | 98 +++++++++
 tb/tb_shift_req_queue.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_pkg.sv
// Shared types and constants for the shift request queue.
package shift_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int SHW_DEF   = 3;

    localparam logic DIR_LEFT  = 1'b1;
    localparam logic DIR_RIGHT = 1'b0;

    // One queued shift request. Field widths follow the default WIDTH/SHW.
    typedef struct packed {
        logic                 lr_en;
        logic                 al_en;
        logic [SHW_DEF-1:0]   shamt;
        logic [WIDTH_DEF-1:0] din;
    } shift_req_t;

endpackage

// File: rtl/shift_req_queue_if.sv
// Request and result handshake bundle for shift_req_queue.
interface shift_req_queue_if #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3,
    parameter int DEPTH = 4
);
    logic                         in_valid;
    logic                         in_ready;
    logic                         in_lr_en;
    logic                         in_al_en;
    logic [SHW-1:0]               in_shamt;
    logic [WIDTH-1:0]             in_din;
    logic                         out_valid;
    logic                         out_ready;
    logic [WIDTH-1:0]             out_dout;
    logic                         out_zero;
    logic [$clog2(DEPTH+1)-1:0]   count;

    // Producer/consumer side.
    modport master (
        output in_valid, in_lr_en, in_al_en, in_shamt, in_din, out_ready,
        input  in_ready, out_valid, out_dout, out_zero, count
    );

    // Queue side.
    modport slave (
        input  in_valid, in_lr_en, in_al_en, in_shamt, in_din, out_ready,
        output in_ready, out_valid, out_dout, out_zero, count
    );
endinterface

// File: rtl/barrel_shifter.sv
// Combinational barrel shifter: left, logical right, arithmetic right.
module barrel_shifter
    import shift_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SHW   = SHW_DEF
) (
    input  logic             lr_en,
    input  logic             al_en,
    input  logic [SHW-1:0]   shamt,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic             fill;
    logic [WIDTH-1:0] stage;

    // Sign fill comes from the original operand MSB, never from an intermediate stage.
    assign fill = al_en && (lr_en == DIR_RIGHT) && din[WIDTH-1];

    // log2(WIDTH) mux stages, stage s shifts by 2**s when shamt[s] is set.
    always_comb begin
        stage = din;
        for (int s = 0; s < SHW; s++) begin
            if (shamt[s]) begin
                if (lr_en == DIR_LEFT) begin
                    stage = stage << (1 << s);
                end else begin
                    stage = (stage >> (1 << s)) |
                            (fill ? ~({WIDTH{1'b1}} >> (1 << s)) : '0);
                end
            end
        end
    end

    assign dout = stage;

endmodule

// File: rtl/shift_req_queue.sv
// Request FIFO feeding a barrel shifter, with a registered output stage.
module shift_req_queue
    import shift_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SHW   = SHW_DEF,
    parameter int DEPTH = 4
) (
    input logic              clk,
    input logic              rst,
    shift_req_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    shift_req_t       mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_dout_q;
    logic             out_zero_q;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    shift_req_t       req;
    shift_req_t       head;
    logic [WIDTH-1:0] shifted;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    // in_ready looks only at full, so a same-cycle pop never frees a slot early.
    assign push  = bus.in_valid && !full;
    assign pop   = !empty && (!out_valid_q || bus.out_ready);

    assign req  = '{lr_en: bus.in_lr_en, al_en: bus.in_al_en,
                    shamt: bus.in_shamt, din: bus.in_din};
    assign head = mem[rd_ptr];

    barrel_shifter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_shifter (
        .lr_en (head.lr_en),
        .al_en (head.al_en),
        .shamt (head.shamt),
        .din   (head.din),
        .dout  (shifted)
    );

    // Request storage; contents are don't-care until the pointers cover them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= req;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (!push && pop) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // Output register: load on pop, otherwise drop valid once consumed and hold data.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_dout_q  <= '0;
            out_zero_q  <= 1'b0;
        end else if (pop) begin
            out_valid_q <= 1'b1;
            out_dout_q  <= shifted;
            out_zero_q  <= (shifted == '0);
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = !full;
    assign bus.out_valid = out_valid_q;
    assign bus.out_dout  = out_dout_q;
    assign bus.out_zero  = out_zero_q;
    assign bus.count     = count_q;

endmodule

// File: tb/tb_shift_req_queue.sv
// Bench for shift_req_queue: directed scenarios plus a randomized scoreboard run.
module tb_shift_req_queue;
    localparam int WIDTH = 8;
    localparam int SHW   = 3;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    shift_req_queue_if #(.WIDTH(WIDTH), .SHW(SHW), .DEPTH(DEPTH)) bus ();

    shift_req_queue #(.WIDTH(WIDTH), .SHW(SHW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference result from plain arithmetic: multiply, divide, signed floor shift.
    function automatic logic [7:0] ref_shift(input logic [7:0] din, input logic [2:0] shamt,
                                             input logic lr, input logic al);
        int v;
        if (lr)
            v = (int'(din) * (1 << int'(shamt))) % 256;
        else if (al && din[7])
            v = ((int'(din) - 256) >>> int'(shamt)) & 255;
        else
            v = int'(din) / (1 << int'(shamt));
        return v[7:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [7:0] din, input logic [2:0] shamt,
                             input logic lr, input logic al);
        bus.in_valid = 1'b1;
        bus.in_din   = din;
        bus.in_shamt = shamt;
        bus.in_lr_en = lr;
        bus.in_al_en = al;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.out_ready = 1'b0;
        drive_req(8'h55, 3'd1, 1'b1, 1'b0);
        step();
        step();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
        n_cmp++; if (bus.out_dout !== 8'h00) begin n_bad++; $display("FAIL reset_dout: got %h expected 00", bus.out_dout); end
        n_cmp++; if (bus.out_zero !== 1'b0) begin n_bad++; $display("FAIL reset_zero: got %b expected 0", bus.out_zero); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        step();
        step();
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.count !== 3'd0)
            begin n_bad++; $display("FAIL reset_no_accept: got valid=%b count=%0d expected 0/0", bus.out_valid, bus.count); end
    endtask

    task automatic test_single_left();
        bus.out_ready = 1'b0;
        drive_req(8'h96, 3'd3, 1'b1, 1'b0);
        step();
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL left_no_bypass: got %b expected 0", bus.out_valid); end
        n_cmp++; if (bus.count !== 3'd1) begin n_bad++; $display("FAIL left_count: got %0d expected 1", bus.count); end
        step();
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL left_valid: got %b expected 1", bus.out_valid); end
        n_cmp++; if (bus.out_dout !== 8'hB0) begin n_bad++; $display("FAIL left_dout: got %h expected b0", bus.out_dout); end
        n_cmp++; if (bus.out_zero !== 1'b0) begin n_bad++; $display("FAIL left_zero: got %b expected 0", bus.out_zero); end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL left_consume: got %b expected 0", bus.out_valid); end
        n_cmp++; if (bus.out_dout !== 8'hB0) begin n_bad++; $display("FAIL left_hold: got %h expected b0", bus.out_dout); end
    endtask

    task automatic test_right();
        logic [7:0] t_din  [4] = '{8'h96, 8'h96, 8'h80, 8'h01};
        logic [2:0] t_sh   [4] = '{3'd2, 3'd2, 3'd7, 3'd1};
        logic       t_al   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [7:0] t_exp  [4] = '{8'hE5, 8'h25, 8'hFF, 8'h00};
        logic       t_zero [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            bus.out_ready = 1'b0;
            drive_req(t_din[i], t_sh[i], 1'b0, t_al[i]);
            step();
            bus.in_valid = 1'b0;
            step();
            n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_dout !== t_exp[i])
                begin n_bad++; $display("FAIL right_%0d_dout: got valid=%b %h expected 1 %h", i, bus.out_valid, bus.out_dout, t_exp[i]); end
            n_cmp++; if (bus.out_zero !== t_zero[i])
                begin n_bad++; $display("FAIL right_%0d_zero: got %b expected %b", i, bus.out_zero, t_zero[i]); end
            bus.out_ready = 1'b1;
            step();
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_q[$];
        logic [7:0] hold;
        logic [7:0] d;
        logic [2:0] sh;
        logic       lr, al;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom); sh = 3'($urandom); lr = 1'($urandom); al = 1'($urandom);
            drive_req(d, sh, lr, al);
            n_cmp++; if (bus.in_ready !== (i < 5))
                begin n_bad++; $display("FAIL bp_in_ready_%0d: got %b expected %b", i, bus.in_ready, (i < 5)); end
            if (i < 5) exp_q.push_back(ref_shift(d, sh, lr, al));
            step();
        end
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_full: got %b expected 0", bus.in_ready); end
        n_cmp++; if (bus.count !== 3'd4) begin n_bad++; $display("FAIL bp_count: got %0d expected 4", bus.count); end
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_dout !== exp_q[0])
            begin n_bad++; $display("FAIL bp_head: got valid=%b %h expected 1 %h", bus.out_valid, bus.out_dout, exp_q[0]); end
        hold = bus.out_dout;
        repeat (3) step();
        n_cmp++; if (bus.out_dout !== hold || bus.out_valid !== 1'b1)
            begin n_bad++; $display("FAIL bp_stable: got valid=%b %h expected 1 %h", bus.out_valid, bus.out_dout, hold); end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            d = exp_q.pop_front();
            n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_dout !== d)
                begin n_bad++; $display("FAIL bp_drain_%0d: got valid=%b %h expected 1 %h", i, bus.out_valid, bus.out_dout, d); end
            step();
        end
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.count !== 3'd0)
            begin n_bad++; $display("FAIL bp_empty: got valid=%b count=%0d expected 0/0", bus.out_valid, bus.count); end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_streaming();
        logic       exp_v;
        logic [7:0] exp_d;
        logic [7:0] ones;
        ones = 8'hFF;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c < 8) drive_req(8'hFF, 3'(c), 1'b1, 1'b0);
            else bus.in_valid = 1'b0;
            exp_v = (c >= 2) && (c < 10);
            n_cmp++; if (bus.count > 3'd1) begin n_bad++; $display("FAIL stream_count_%0d: got %0d expected <=1", c, bus.count); end
            n_cmp++; if (bus.out_valid !== exp_v)
                begin n_bad++; $display("FAIL stream_valid_%0d: got %b expected %b", c, bus.out_valid, exp_v); end
            if (exp_v) begin
                exp_d = ones << (c - 2);
                n_cmp++; if (bus.out_dout !== exp_d)
                    begin n_bad++; $display("FAIL stream_dout_%0d: got %h expected %h", c, bus.out_dout, exp_d); end
            end
            step();
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [7:0] d, e;
        logic [2:0] sh;
        logic       lr, al;
        int         seen;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_req(8'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
            step();
        end
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.count !== 3'd3 || bus.out_valid !== 1'b1)
            begin n_bad++; $display("FAIL mid_pre: got count=%0d valid=%b expected 3/1", bus.count, bus.out_valid); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++; if (bus.count !== 3'd0 || bus.out_valid !== 1'b0)
            begin n_bad++; $display("FAIL mid_reset: got count=%0d valid=%b expected 0/0", bus.count, bus.out_valid); end
        d = 8'($urandom); sh = 3'($urandom); lr = 1'($urandom); al = 1'($urandom);
        e = ref_shift(d, sh, lr, al);
        drive_req(d, sh, lr, al);
        step();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (bus.out_valid === 1'b1) begin
                seen++;
                n_cmp++; if (bus.out_dout !== e)
                    begin n_bad++; $display("FAIL mid_dout: got %h expected %h", bus.out_dout, e); end
            end
            step();
        end
        n_cmp++; if (seen !== 1) begin n_bad++; $display("FAIL mid_results: got %0d expected 1", seen); end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        logic [7:0] prev_d, e;
        logic       prev_z;
        logic       hold_prev;
        int         occ;
        hold_prev = 1'b0;
        prev_d = '0;
        prev_z = 1'b0;
        for (int c = 0; c < 420; c++) begin
            if (c < 400) begin
                bus.in_valid = 1'($urandom);
                bus.in_din   = 8'($urandom);
                bus.in_shamt = 3'($urandom);
                bus.in_lr_en = 1'($urandom);
                bus.in_al_en = 1'($urandom);
                bus.out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                bus.in_valid = 1'b0;
                bus.out_ready = 1'b1;
            end
            @(negedge clk);
            if (hold_prev) begin
                n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_dout !== prev_d || bus.out_zero !== prev_z)
                    begin n_bad++; $display("FAIL rnd_stable_%0d: got %b %h %b expected 1 %h %b", c, bus.out_valid, bus.out_dout, bus.out_zero, prev_d, prev_z); end
            end
            occ = exp_q.size() - int'(bus.out_valid);
            n_cmp++; if (int'(bus.count) !== occ)
                begin n_bad++; $display("FAIL rnd_count_%0d: got %0d expected %0d", c, bus.count, occ); end
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL rnd_extra_%0d: got %h expected no result", c, bus.out_dout);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.out_dout !== e || bus.out_zero !== (e == 8'h00))
                        begin n_bad++; $display("FAIL rnd_dout_%0d: got %h z=%b expected %h z=%b", c, bus.out_dout, bus.out_zero, e, (e == 8'h00)); end
                end
            end
            if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1)
                exp_q.push_back(ref_shift(bus.in_din, bus.in_shamt, bus.in_lr_en, bus.in_al_en));
            hold_prev = bus.out_valid && !bus.out_ready;
            prev_d = bus.out_dout;
            prev_z = bus.out_zero;
            @(posedge clk);
            #1;
        end
        n_cmp++; if (exp_q.size() != 0)
            begin n_bad++; $display("FAIL rnd_drain: got %0d outstanding expected 0", exp_q.size()); end
        bus.out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_lr_en  = 1'b0;
        bus.in_al_en  = 1'b0;
        bus.in_shamt  = '0;
        bus.in_din    = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single_left();
        test_right();
        test_backpressure();
        test_streaming();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
